mux_sel_pipe: RTL and testbench

Parametrised, pipelined N:1 word selector with a valid/ready handshake on both sides. It is the successor to the flat combinational 32:1 register-read mux. It selects one of NUM_OPTS packed input words per accepted request and registers the result through a two-entry elastic buffer. This lets it sit between the register file and the execute stage without breaking timing or throughput. It also adds out-of-range select detection and a configurable output value when no data is valid.

---
 rtl/mux_sel_pipe.sv | 135 +++++++++++++
 tb/tb_mux_sel_pipe.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/mux_sel_pipe.sv
// Pipelined N:1 word selector with valid/ready on both sides.
// The selected word is captured into a two-entry elastic buffer (head + skid).
module mux_sel_pipe #(
    parameter int WIDTH        = 32,
    parameter int NUM_OPTS     = 32,
    parameter int SEL_W        = 5,
    parameter int ZERO_INVALID = 0
) (
    input  logic                      clock,
    input  logic                      reset_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [SEL_W-1:0]          in_sel,
    input  logic [NUM_OPTS*WIDTH-1:0] in_opts,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [WIDTH-1:0]          out_data,
    output logic [SEL_W-1:0]          out_sel,
    output logic                      out_err
);

    generate
        if (NUM_OPTS < 2 || NUM_OPTS > 256 || (2 ** SEL_W) < NUM_OPTS) begin : g_bad_params
            $error("mux_sel_pipe: NUM_OPTS must be 2..256 and fit in SEL_W bits");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_EMPTY,
        S_ONE,
        S_TWO
    } state_t;

    state_t             r_state;
    logic               r_in_ready;
    logic               r_out_valid;
    logic [WIDTH-1:0]   r_head_data;
    logic [SEL_W-1:0]   r_head_sel;
    logic               r_head_err;
    logic [WIDTH-1:0]   r_skid_data;
    logic [SEL_W-1:0]   r_skid_sel;
    logic               r_skid_err;

    logic [WIDTH-1:0]   w_sel_data;
    logic               w_sel_err;
    logic               w_accept;
    logic               w_drain;
    logic               w_blank;

    // NOTE: defaults before the loop keep this purely combinational (no latch).
    always_comb begin
        w_sel_data = '0;
        w_sel_err  = (int'(in_sel) >= NUM_OPTS);
        for (int k = 0; k < NUM_OPTS; k++) begin
            if (int'(in_sel) == k) begin
                w_sel_data = in_opts[k*WIDTH +: WIDTH];
            end
        end
    end

    assign w_accept = in_valid && r_in_ready;
    assign w_drain  = r_out_valid && out_ready;

    // NOTE: all state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_state     <= S_EMPTY;
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b0;
            r_head_data <= '0;
            r_head_sel  <= '0;
            r_head_err  <= 1'b0;
            r_skid_data <= '0;
            r_skid_sel  <= '0;
            r_skid_err  <= 1'b0;
        end else begin
            case (r_state)
                S_EMPTY: begin
                    r_in_ready <= 1'b1;
                    if (w_accept) begin
                        r_head_data <= w_sel_data;
                        r_head_sel  <= in_sel;
                        r_head_err  <= w_sel_err;
                        r_out_valid <= 1'b1;
                        r_state     <= S_ONE;
                    end
                end
                S_ONE: begin
                    case ({w_accept, w_drain})
                        2'b11: begin
                            r_head_data <= w_sel_data;
                            r_head_sel  <= in_sel;
                            r_head_err  <= w_sel_err;
                        end
                        2'b10: begin
                            r_skid_data <= w_sel_data;
                            r_skid_sel  <= in_sel;
                            r_skid_err  <= w_sel_err;
                            r_in_ready  <= 1'b0;
                            r_state     <= S_TWO;
                        end
                        2'b01: begin
                            r_out_valid <= 1'b0;
                            r_state     <= S_EMPTY;
                        end
                        default: ;
                    endcase
                end
                S_TWO: begin
                    if (w_drain) begin
                        r_head_data <= r_skid_data;
                        r_head_sel  <= r_skid_sel;
                        r_head_err  <= r_skid_err;
                        r_in_ready  <= 1'b1;
                        r_state     <= S_ONE;
                    end
                end
                default: begin
                    r_in_ready  <= 1'b0;
                    r_out_valid <= 1'b0;
                    r_state     <= S_EMPTY;
                end
            endcase
        end
    end

    // Blank the result fields while idle only when configured to do so.
    assign w_blank   = (ZERO_INVALID != 0) && !r_out_valid;
    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out_data  = w_blank ? '0 : r_head_data;
    assign out_sel   = w_blank ? '0 : r_head_sel;
    assign out_err   = w_blank ? 1'b0 : r_head_err;

endmodule

// File: tb/tb_mux_sel_pipe.sv
// Bench for mux_sel_pipe: a 32-option/hold instance and a 24-option/zeroing
// instance share stimulus and are compared every cycle against a queue model.
module tb_mux_sel_pipe;

    logic          clock;
    logic          reset_n;
    logic          in_valid;
    logic [4:0]    in_sel;
    logic          out_ready;
    logic [31:0]   opt_words [32];
    logic [1023:0] opts_flat;

    logic          a_in_ready, a_out_valid, a_out_err;
    logic [31:0]   a_out_data;
    logic [4:0]    a_out_sel;
    logic          b_in_ready, b_out_valid, b_out_err;
    logic [31:0]   b_out_data;
    logic [4:0]    b_out_sel;

    int n_checks = 0;
    int n_errors = 0;

    mux_sel_pipe #(.WIDTH(32), .NUM_OPTS(32), .SEL_W(5), .ZERO_INVALID(0)) u_dut_a (
        .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .in_ready(a_in_ready),
        .in_sel(in_sel), .in_opts(opts_flat), .out_valid(a_out_valid), .out_ready(out_ready),
        .out_data(a_out_data), .out_sel(a_out_sel), .out_err(a_out_err)
    );

    mux_sel_pipe #(.WIDTH(32), .NUM_OPTS(24), .SEL_W(5), .ZERO_INVALID(1)) u_dut_b (
        .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .in_ready(b_in_ready),
        .in_sel(in_sel), .in_opts(opts_flat[24*32-1:0]), .out_valid(b_out_valid), .out_ready(out_ready),
        .out_data(b_out_data), .out_sel(b_out_sel), .out_err(b_out_err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always_comb begin
        for (int k = 0; k < 32; k++) opts_flat[k*32 +: 32] = opt_words[k];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Queue model: each entry is one accepted request with the result each instance must show.
    typedef struct packed {
        logic [4:0]  sel;
        logic [31:0] da;
        logic [31:0] db;
        logic        eb;
    } ent_t;

    ent_t q[$];
    ent_t last_a;
    bit   m_ready = 0;
    bit   m_live  = 0;

    function automatic ent_t make_ent(input logic [4:0] sel);
        ent_t e;
        e.sel = sel;
        e.da  = opt_words[sel];
        e.eb  = (sel >= 5'd24);
        e.db  = e.eb ? 32'h0 : opt_words[sel];
        return e;
    endfunction

    always @(posedge clock) begin
        bit acc, drn;
        if (!reset_n) begin
            q.delete();
            m_ready = 0;
            m_live  = 1;
            last_a  = '0;
        end else if (m_live) begin
            acc = in_valid && m_ready;
            drn = (q.size() > 0) && out_ready;
            if (drn) void'(q.pop_front());
            if (acc) q.push_back(make_ent(in_sel));
            m_ready = (q.size() < 2);
            if (q.size() > 0) last_a = q[0];
        end
    end

    always @(negedge clock) begin
        if (m_live) begin
            bit   v;
            ent_t e;
            v = (q.size() > 0);
            e = v ? q[0] : last_a;
            check("a_valid", {31'b0, a_out_valid}, {31'b0, v});
            check("a_ready", {31'b0, a_in_ready}, {31'b0, m_ready});
            check("a_data", a_out_data, e.da);
            check("a_sel", {27'b0, a_out_sel}, {27'b0, e.sel});
            check("a_err", {31'b0, a_out_err}, 32'h0);
            check("b_valid", {31'b0, b_out_valid}, {31'b0, v});
            check("b_ready", {31'b0, b_in_ready}, {31'b0, m_ready});
            check("b_data", b_out_data, v ? e.db : 32'h0);
            check("b_sel", {27'b0, b_out_sel}, v ? {27'b0, e.sel} : 32'h0);
            check("b_err", {31'b0, b_out_err}, {31'b0, v & e.eb});
        end
    end

    task automatic set_opts(input logic [31:0] base);
        for (int k = 0; k < 32; k++) opt_words[k] = base + k;
    endtask

    // Called just after a falling edge; returns just after the falling edge that follows the accept.
    task automatic send(input logic [4:0] sel);
        bit r;
        bit done = 0;
        in_valid = 1'b1;
        in_sel   = sel;
        for (int t = 0; t < 50 && !done; t++) begin
            r = a_in_ready;
            @(negedge clock);
            if (r) done = 1;
        end
        check("send_accepted", {31'b0, done}, 32'h1);
        in_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n   = 1'b0;
        in_valid  = 1'b0;
        in_sel    = '0;
        out_ready = 1'b0;
        set_opts(32'hA000_0000);

        // Reset defaults, and in_ready rising one cycle after release.
        repeat (2) @(negedge clock);
        check("rst_a_valid", {31'b0, a_out_valid}, 32'h0);
        check("rst_a_ready", {31'b0, a_in_ready}, 32'h0);
        check("rst_a_data", a_out_data, 32'h0);
        check("rst_b_data", b_out_data, 32'h0);
        reset_n = 1'b1;
        check("rel_ready_low", {31'b0, a_in_ready}, 32'h0);
        @(negedge clock);
        check("rel_ready_high", {31'b0, a_in_ready}, 32'h1);

        // Single transfer; options scrambled after acceptance must not matter.
        out_ready = 1'b1;
        send(5'd13);
        set_opts(32'h5555_0000);
        check("single_valid", {31'b0, a_out_valid}, 32'h1);
        check("single_data", a_out_data, 32'hA000_000D);
        check("single_sel", {27'b0, a_out_sel}, 32'd13);
        check("single_err", {31'b0, a_out_err}, 32'h0);
        @(negedge clock);
        check("single_gone", {31'b0, a_out_valid}, 32'h0);
        check("hold_a_data", a_out_data, 32'hA000_000D);
        check("zero_b_data", b_out_data, 32'h0);
        set_opts(32'hA000_0000);

        // Full throughput: 32 back-to-back requests.
        for (int k = 0; k < 32; k++) begin
            send(k[4:0]);
            check("thru_valid", {31'b0, a_out_valid}, 32'h1);
            check("thru_data", a_out_data, 32'hA000_0000 + k);
            check("thru_ready", {31'b0, a_in_ready}, 32'h1);
        end
        @(negedge clock);
        check("thru_end", {31'b0, a_out_valid}, 32'h0);

        // Backpressure: two accepted, third held until drain begins.
        out_ready = 1'b0;
        send(5'd3);
        check("bp_ready_one", {31'b0, a_in_ready}, 32'h1);
        send(5'd7);
        check("bp_ready_two", {31'b0, a_in_ready}, 32'h0);
        fork
            send(5'd9);
            begin
                for (int i = 0; i < 3; i++) begin
                    check("bp_stable_data", a_out_data, 32'hA000_0003);
                    check("bp_stable_sel", {27'b0, a_out_sel}, 32'd3);
                    @(negedge clock);
                end
                out_ready = 1'b1;
                @(negedge clock);
                check("bp_second", {27'b0, a_out_sel}, 32'd7);
                check("bp_ready_back", {31'b0, a_in_ready}, 32'h1);
            end
        join
        check("bp_third", a_out_data, 32'hA000_0009);
        @(negedge clock);
        check("bp_empty", {31'b0, a_out_valid}, 32'h0);

        // Out-of-range select on the 24-option instance.
        send(5'd27);
        check("oor_b_data", b_out_data, 32'h0);
        check("oor_b_err", {31'b0, b_out_err}, 32'h1);
        check("oor_a_data", a_out_data, 32'hA000_001B);
        send(5'd23);
        check("inr_b_data", b_out_data, 32'hA000_0017);
        check("inr_b_err", {31'b0, b_out_err}, 32'h0);
        @(negedge clock);
        check("idle_b_zero", b_out_data, 32'h0);
        check("idle_a_hold", a_out_data, 32'hA000_0017);

        // Reset while full, with a request offered during the reset cycle.
        out_ready = 1'b0;
        send(5'd5);
        send(5'd6);
        check("mid_full", {31'b0, a_in_ready}, 32'h0);
        reset_n  = 1'b0;
        in_valid = 1'b1;
        in_sel   = 5'd8;
        @(negedge clock);
        check("mid_rst_valid", {31'b0, a_out_valid}, 32'h0);
        check("mid_rst_data", a_out_data, 32'h0);
        reset_n  = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(negedge clock);
        check("mid_no_stale", {31'b0, a_out_valid}, 32'h0);
        check("mid_ready", {31'b0, a_in_ready}, 32'h1);
        send(5'd2);
        check("post_rst_data", a_out_data, 32'hA000_0002);
        repeat (3) @(negedge clock);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
